tt_keyframe_ctrl: RTL and testbench
===================================

TT_KEYFRAME_CTRL -- requirements
Module: tt_keyframe_ctrl

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 4, clocks per serial bit (even, >=4).
REQ-002 SHALL have parameter NIBBLE_W, default 4, data bits per frame (fixed at 4 in this release).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on posedge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, receiver enable.
REQ-006 SHALL have port num, input, 1, asynchronous serial key line; idle low.
REQ-007 SHALL have port ready, input, 1, consumer accepts samplednum.
REQ-008 SHALL have port samplednum, output, 4, last accepted nibble, MSB received first.
REQ-009 SHALL have port valid, output, 1, samplednum holds unconsumed data.
REQ-010 SHALL have port sample, output, 1, one-cycle strobe when samplednum loads.
REQ-011 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have port err, output, 1, sticky framing/parity error flag.
REQ-013 SHALL have port overrun, output, 1, sticky flag for a frame lost because valid was still set.

Function
REQ-014 SHALL pass num through a 2-flop synchronizer; all decisions use the synchronized value (num_s).
REQ-015 SHALL implement FSM states IDLE, START, DATA, [PARITY], STOP, LOAD.
REQ-016 IDLE->START when en=1 and num_s=1; the bit counter is cleared.
REQ-017 START: after BIT_CYCLES/2 cycles, num_s=1 -> DATA; num_s=0 -> IDLE (glitch reject, no flag).
REQ-018 DATA: SHALL sample num_s every BIT_CYCLES cycles and shift it into the shift register at the LSB (MSB first); after the 4th bit -> PARITY if enabled, else STOP.
REQ-019 STOP: SHALL sample num_s after BIT_CYCLES cycles; 0 -> LOAD; 1 -> set err, discard the frame, go to IDLE.
REQ-020 LOAD (one cycle), valid=0 or ready=1: SHALL load samplednum, set valid and pulse sample, then go to IDLE.
REQ-021 LOAD, valid=1 and ready=0: SHALL keep samplednum, set overrun, drop the frame and pulse no sample.
REQ-022 Handshake: valid SHALL clear the cycle after valid&&ready, unless a LOAD occurs in the same cycle, in which case valid stays 1 with the new data.
REQ-023 en=0 in any non-IDLE state: SHALL return to IDLE next cycle, discarding partial bits; valid and samplednum are unaffected.
REQ-024 en=0 SHALL clear err and overrun.
REQ-025 Latency from start detection to the sample strobe SHALL be BIT_CYCLES/2 + (NIBBLE_W+1+P)*BIT_CYCLES + 1 cycles, where P = 1 with parity and 0 without.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, samplednum=0, valid=0, sample=0, busy=0, err=0, overrun=0, and clear the synchronizer, counters and shift register.
REQ-027 Reset release mid-frame SHALL resume in IDLE and require a fresh start bit.

Configuration
REQ-028 With macro TT_KEYFRAME_PARITY_EN defined: SHALL add the PARITY state, sampled one bit after data; even parity over 4 data bits + parity bit; mismatch sets err and discards the frame.
REQ-029 Without TT_KEYFRAME_PARITY_EN: no PARITY state exists; frame = start + 4 data + stop.

Structure
REQ-030 Shared package tt_keyframe_pkg SHALL hold the state enum typedef, NIBBLE_W and the default BIT_CYCLES.
REQ-031 The bit-timing counter with mid-bit/bit-end ticks SHALL be sub-module tt_keyframe_bittimer.

Verification (BIT_CYCLES=4)
REQ-032 Frame 1,1,0,1,0,0 with ready=1 SHALL give samplednum=4'hA, one sample pulse, valid=1 for 1 cycle, err=0.
REQ-033 Frames 1010 then 0101 with ready=0 SHALL give samplednum=4'hA held, overrun=1, exactly one sample pulse.
REQ-034 A 1-cycle num pulse in IDLE SHALL return the FSM to IDLE with valid=0 and err=0.
REQ-035 Frame 0011 with stop bit=1 SHALL give err=1, valid=0 and samplednum unchanged; en=0 SHALL then clear err.
REQ-036 rst_n low after the 2nd data bit then high, followed by frame 1111, SHALL give samplednum=4'hF with no residue.
REQ-037 With TT_KEYFRAME_PARITY_EN, frame 1010 with parity 1 SHALL give err=1 and valid=0; with parity 0 it SHALL give samplednum=4'hA.

Source files
------------

// File: rtl/tt_keyframe_pkg.sv
// Shared types and constants for the serial key-frame receiver.
// Defining TT_KEYFRAME_PARITY_EN adds an even-parity bit after the data nibble.
package tt_keyframe_pkg;

  localparam int NIBBLE_W       = 4;
  localparam int DEF_BIT_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef TT_KEYFRAME_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_LOAD   = 3'd5
  } kf_state_e;

`ifdef TT_KEYFRAME_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_ok(input logic [NIBBLE_W-1:0] data, input logic par);
    return ~(^{data, par});
  endfunction
`endif

endpackage

// File: rtl/tt_keyframe_bittimer.sv
// Bit-period counter: mid_tick half a bit after clear, end_tick every full bit.
module tt_keyframe_bittimer
  import tt_keyframe_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic mid_tick,
  output logic end_tick
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] END_CNT = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // Free-running bit counter, restarted on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear || (cnt_r == END_CNT)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign mid_tick = (cnt_r == MID_CNT);
  assign end_tick = (cnt_r == END_CNT);

endmodule

// File: rtl/tt_keyframe_ctrl.sv
// Serial key-frame receiver: start bit (high), 4 data bits MSB first, optional
// even parity (TT_KEYFRAME_PARITY_EN), stop bit (low); valid/ready output nibble.
module tt_keyframe_ctrl #(
  parameter int BIT_CYCLES = tt_keyframe_pkg::DEF_BIT_CYCLES,
  parameter int NIBBLE_W   = tt_keyframe_pkg::NIBBLE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                num,
  input  logic                ready,
  output logic [NIBBLE_W-1:0] samplednum,
  output logic                valid,
  output logic                sample,
  output logic                busy,
  output logic                err,
  output logic                overrun
);
  import tt_keyframe_pkg::*;

  localparam int BCNT_W = $clog2(NIBBLE_W);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(NIBBLE_W - 1);

  kf_state_e           state_r, state_next_s;
  logic [1:0]          num_sync_r;
  logic                num_s;
  logic [BCNT_W-1:0]   bit_cnt_r;
  logic [NIBBLE_W-1:0] shift_r, samplednum_r;
  logic                valid_r, sample_r, busy_r, err_r, overrun_r;
  logic                shift_en_s, bit_clr_s, load_s, ovr_set_s, err_set_s;
  logic                mid_tick_s, end_tick_s, timer_clr_s;

  assign num_s       = num_sync_r[1];
  assign timer_clr_s = (state_next_s != state_r);

  tt_keyframe_bittimer #(.BIT_CYCLES(BIT_CYCLES)) u_bittimer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clr_s),
    .mid_tick (mid_tick_s),
    .end_tick (end_tick_s)
  );

  // Two-flop synchronizer for the asynchronous key line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_sync_r <= 2'b00;
    end else begin
      num_sync_r <= {num_sync_r[0], num};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_next_s = state_r;
    shift_en_s   = 1'b0;
    bit_clr_s    = 1'b0;
    load_s       = 1'b0;
    ovr_set_s    = 1'b0;
    err_set_s    = 1'b0;
    if (!en) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (num_s) begin
            state_next_s = ST_START;
            bit_clr_s    = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_START: begin
          if (mid_tick_s) begin
            state_next_s = num_s ? ST_DATA : ST_IDLE;
          end else begin
            state_next_s = ST_START;
          end
        end
        ST_DATA: begin
          if (end_tick_s) begin
            shift_en_s = 1'b1;
            if (bit_cnt_r == LAST_BIT) begin
`ifdef TT_KEYFRAME_PARITY_EN
              state_next_s = ST_PARITY;
`else
              state_next_s = ST_STOP;
`endif
            end else begin
              state_next_s = ST_DATA;
            end
          end else begin
            state_next_s = ST_DATA;
          end
        end
`ifdef TT_KEYFRAME_PARITY_EN
        ST_PARITY: begin
          if (end_tick_s) begin
            if (parity_ok(shift_r, num_s)) begin
              state_next_s = ST_STOP;
            end else begin
              err_set_s    = 1'b1;
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_PARITY;
          end
        end
`endif
        ST_STOP: begin
          if (end_tick_s) begin
            if (!num_s) begin
              state_next_s = ST_LOAD;
            end else begin
              err_set_s    = 1'b1;
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_STOP;
          end
        end
        ST_LOAD: begin
          // A pending, unconsumed nibble wins over the new frame
          if (!valid_r || ready) begin
            load_s = 1'b1;
          end else begin
            ovr_set_s = 1'b1;
          end
          state_next_s = ST_IDLE;
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // Shift register, output nibble, handshake and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r    <= '0;
      shift_r      <= '0;
      samplednum_r <= '0;
      valid_r      <= 1'b0;
      sample_r     <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (bit_clr_s) begin
        bit_cnt_r <= '0;
        shift_r   <= '0;
      end else if (shift_en_s) begin
        bit_cnt_r <= bit_cnt_r + BCNT_W'(1);
        shift_r   <= {shift_r[NIBBLE_W-2:0], num_s};
      end
      if (load_s) begin
        samplednum_r <= shift_r;
        valid_r      <= 1'b1;
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
      sample_r <= load_s;
      busy_r   <= (state_next_s != ST_IDLE);
      if (!en) begin
        err_r     <= 1'b0;
        overrun_r <= 1'b0;
      end else begin
        err_r     <= err_r | err_set_s;
        overrun_r <= overrun_r | ovr_set_s;
      end
    end
  end

  assign samplednum = samplednum_r;
  assign valid      = valid_r;
  assign sample     = sample_r;
  assign busy       = busy_r;
  assign err        = err_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_tt_keyframe_ctrl.sv
// Self-checking bench for tt_keyframe_ctrl: vector table, corner sequences and
// randomized frames against a frame-level model (honours TT_KEYFRAME_PARITY_EN).
module tb_tt_keyframe_ctrl;

  localparam int B = 4;
`ifdef TT_KEYFRAME_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = B / 2 + (4 + 1 + P) * B + 1;
  localparam int GAP = 3 * B;

  logic       clk = 1'b0;
  logic       rst_n, en, num, ready;
  logic [3:0] samplednum;
  logic       valid, sample, busy, err, overrun;

  int total = 0;
  int bad   = 0;

  tt_keyframe_ctrl #(.BIT_CYCLES(B), .NIBBLE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .num        (num),
    .ready      (ready),
    .samplednum (samplednum),
    .valid      (valid),
    .sample     (sample),
    .busy       (busy),
    .err        (err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Event monitor: pulse and cycle counters plus timestamps for latency.
  int   cyc = 0;
  int   n_samp = 0, n_vcyc = 0, n_bcyc = 0, t_busy = 0, t_samp = 0;
  logic busy_q = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sample) begin n_samp++; t_samp = cyc; end
    if (valid) n_vcyc++;
    if (busy) n_bcyc++;
    if (busy && !busy_q) t_busy = cyc;
    busy_q = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    num = b;
    tick(B);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic stop);
    drive_bit(1'b1);
    for (int i = 3; i >= 0; i--) drive_bit(d[i]);
`ifdef TT_KEYFRAME_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    num = 1'b0;
    tick(GAP);
  endtask

`ifdef TT_KEYFRAME_PARITY_EN
  task automatic send_frame_par(input logic [3:0] d, input logic par, input logic stop);
    drive_bit(1'b1);
    for (int i = 3; i >= 0; i--) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
    num = 1'b0;
    tick(GAP);
  endtask
`endif

  task automatic en_clear();
    en  = 1'b0;
    num = 1'b0;
    tick(3);
    en = 1'b1;
    tick(1);
  endtask

  typedef struct {
    logic       clr;
    logic       rdy;
    logic [3:0] d;
    logic       stop;
    logic [3:0] e_data;
    logic       e_valid;
    logic       e_err;
    logic       e_ovr;
    int         e_samp;
  } vec_t;

  vec_t tbl[8];

  int         s0, v0, b0;
  logic [3:0] m_data, rd;
  logic       m_valid, m_err, m_ovr, rrdy, rstop, rpar_bad;
  int         m_samp;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 4'hC, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1};
    tbl[1] = '{1'b0, 1'b1, 4'h5, 1'b0, 4'h5, 1'b0, 1'b0, 1'b0, 1};
    tbl[2] = '{1'b0, 1'b0, 4'hA, 1'b0, 4'hA, 1'b1, 1'b0, 1'b0, 1};
    tbl[3] = '{1'b0, 1'b0, 4'h5, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1, 0};
    tbl[4] = '{1'b1, 1'b1, 4'h3, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 0};
    tbl[5] = '{1'b1, 1'b1, 4'hF, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1};
    tbl[6] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1};
    tbl[7] = '{1'b0, 1'b1, 4'h9, 1'b0, 4'h9, 1'b0, 1'b0, 1'b0, 1};

    // Reset state
    rst_n = 1'b0; en = 1'b0; num = 1'b0; ready = 1'b0;
    tick(3);
    chk("rst samplednum", samplednum, 0);
    chk("rst valid", valid, 0);
    chk("rst sample", sample, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    chk("rst overrun", overrun, 0);
    rst_n = 1'b1; en = 1'b1;
    tick(4);

    // One-cycle glitch is rejected after half a bit
    b0 = n_bcyc;
    num = 1'b1; tick(1); num = 1'b0;
    tick(12);
    chk("glitch busy cycles", n_bcyc - b0, B / 2);
    chk("glitch busy", busy, 0);
    chk("glitch valid", valid, 0);
    chk("glitch err", err, 0);

    // Basic frame 1,1,0,1,0,0 with ready high
    ready = 1'b1;
    s0 = n_samp; v0 = n_vcyc;
    send_frame(4'hA, 1'b0);
    chk("basic samplednum", samplednum, 4'hA);
    chk("basic sample pulses", n_samp - s0, 1);
    chk("basic valid cycles", n_vcyc - v0, 1);
    chk("basic err", err, 0);
    chk("basic latency", t_samp - t_busy, LAT);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].clr) en_clear();
      ready = tbl[i].rdy;
      s0 = n_samp;
      send_frame(tbl[i].d, tbl[i].stop);
      chk($sformatf("tbl%0d samplednum", i), samplednum, tbl[i].e_data);
      chk($sformatf("tbl%0d valid", i), valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d err", i), err, tbl[i].e_err);
      chk($sformatf("tbl%0d overrun", i), overrun, tbl[i].e_ovr);
      chk($sformatf("tbl%0d sample pulses", i), n_samp - s0, tbl[i].e_samp);
    end

`ifdef TT_KEYFRAME_PARITY_EN
    // Parity: 1010 with parity 1 is odd -> error; parity 0 loads
    en_clear();
    ready = 1'b1;
    s0 = n_samp;
    send_frame_par(4'hA, 1'b1, 1'b0);
    chk("par bad err", err, 1);
    chk("par bad valid", valid, 0);
    chk("par bad samplednum", samplednum, 4'h9);
    chk("par bad pulses", n_samp - s0, 0);
    en_clear();
    s0 = n_samp;
    send_frame_par(4'hA, 1'b0, 1'b0);
    chk("par good samplednum", samplednum, 4'hA);
    chk("par good err", err, 0);
    chk("par good pulses", n_samp - s0, 1);
`endif

    // Reset after the second data bit, then a clean 1111 frame
    ready = 1'b1;
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst samplednum", samplednum, 0);
    chk("midrst busy", busy, 0);
    chk("midrst valid", valid, 0);
    num = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    s0 = n_samp;
    send_frame(4'hF, 1'b0);
    chk("postrst samplednum", samplednum, 4'hF);
    chk("postrst err", err, 0);
    chk("postrst pulses", n_samp - s0, 1);

    // Enable drop mid-frame discards the partial frame, keeps valid data
    ready = 1'b0;
    send_frame(4'h6, 1'b0);
    chk("pre-drop valid", valid, 1);
    s0 = n_samp;
    drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b1);
    en = 1'b0; num = 1'b0;
    tick(1);
    chk("drop busy", busy, 0);
    chk("drop valid", valid, 1);
    tick(3);
    en = 1'b1;
    tick(GAP);
    chk("drop samplednum", samplednum, 4'h6);
    chk("drop pulses", n_samp - s0, 0);
    chk("drop busy idle", busy, 0);

    // Randomized frames against the frame-level model
    m_data = 4'h6; m_valid = 1'b1; m_err = 1'b0; m_ovr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      rd       = 4'($urandom);
      rrdy     = 1'($urandom_range(0, 1));
      rpar_bad = 1'b0;
      rstop    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        en_clear();
        m_err = 1'b0;
        m_ovr = 1'b0;
      end
      ready = rrdy;
      if (rrdy) m_valid = 1'b0;
      s0 = n_samp;
`ifdef TT_KEYFRAME_PARITY_EN
      if (!rstop && $urandom_range(0, 5) == 0) rpar_bad = 1'b1;
      if (rpar_bad) send_frame_par(rd, ~(^rd), 1'b0);
      else          send_frame(rd, rstop);
`else
      send_frame(rd, rstop);
`endif
      m_samp = 0;
      if (rstop || rpar_bad) begin
        m_err = 1'b1;
      end else if (m_valid) begin
        m_ovr = 1'b1;
      end else begin
        m_data  = rd;
        m_valid = !rrdy;
        m_samp  = 1;
      end
      chk($sformatf("rnd%0d samplednum", k), samplednum, m_data);
      chk($sformatf("rnd%0d valid", k), valid, m_valid);
      chk($sformatf("rnd%0d err", k), err, m_err);
      chk($sformatf("rnd%0d overrun", k), overrun, m_ovr);
      chk($sformatf("rnd%0d pulses", k), n_samp - s0, m_samp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
